// File: rtl/stream_share_ctrl_pkg.sv
// stream_share_ctrl_pkg: width helpers shared by the stream sharing controller and its FIFOs.
//   clog2     - ceiling log2 usable in parameter expressions
//   ch_width  - index width of at least one bit (channel tags, FIFO pointers, gap counter)
//   ch_lsb    - bit offset of channel ch inside a flattened per-channel bus
package stream_share_ctrl_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ch_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two >= 2, asynchronous active-high reset.
//   clk, rst      clock and reset (reset empties the FIFO)
//   push, wdata   write request and data; ignored when full unless the same cycle also pops
//   pop           read request; ignored when empty
//   rdata         head entry (valid while !empty)
//   full, empty   occupancy status
module sync_fifo
    import stream_share_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = ch_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = wptr == rptr;
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/stream_share_ctrl.sv
// stream_share_ctrl: time-shares one in-order streaming DSP block between N_CHANNELS sample streams.
//   clk, rst                   clock, asynchronous active-high reset (shared block must be reset too)
//   in_data, in_nd             flattened per-channel samples (channel c at [c*WIDTH +: WIDTH]) and strobes
//   dsp_in_data, dsp_in_nd     registered sample and strobe into the shared block
//   dsp_out_data, dsp_out_nd   result and strobe from the shared block
//   out_data, out_nd, out_ch   registered routed result, one-cycle strobe, originating channel
//   overflow                   sticky per-channel flag: a sample was dropped on a full FIFO
//   tag_error                  sticky flag: a result arrived with nothing in flight
module stream_share_ctrl
    import stream_share_ctrl_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int N_CHANNELS = 2,
    parameter  int FIFO_DEPTH = 4,
    parameter  int TAG_DEPTH  = 8,
    parameter  int MIN_GAP    = 0,
    localparam int CH_W       = ch_width(N_CHANNELS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CHANNELS*WIDTH-1:0] in_data,
    input  logic [N_CHANNELS-1:0]      in_nd,
    output logic [WIDTH-1:0]           dsp_in_data,
    output logic                       dsp_in_nd,
    input  logic [WIDTH-1:0]           dsp_out_data,
    input  logic                       dsp_out_nd,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_nd,
    output logic [CH_W-1:0]            out_ch,
    output logic [N_CHANNELS-1:0]      overflow,
    output logic                       tag_error
);
    localparam int GAP_W = ch_width(MIN_GAP + 1);

    logic [N_CHANNELS-1:0] fifo_empty;
    logic [N_CHANNELS-1:0] fifo_full;
    logic [N_CHANNELS-1:0] grant;
    logic [WIDTH-1:0]      fifo_q [N_CHANNELS];
    logic [CH_W-1:0]       last;
    logic [CH_W-1:0]       pick;
    logic [CH_W-1:0]       cand;
    logic [CH_W-1:0]       tag_q;
    logic                  found;
    logic                  issue;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_pop;
    logic [GAP_W-1:0]      gap;

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
        sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_nd[c]),
            .pop   (grant[c]),
            .wdata (in_data[ch_lsb(c, WIDTH) +: WIDTH]),
            .rdata (fifo_q[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
        );
    end

    // Tag FIFO mirrors the shared block's in-order pipeline: one channel index per sample in flight.
    sync_fifo #(.WIDTH(CH_W), .DEPTH(TAG_DEPTH)) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (tag_pop),
        .wdata (pick),
        .rdata (tag_q),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign tag_pop = dsp_out_nd && !tag_empty;

    // Round-robin: first non-empty channel found searching upward from last+1, wrapping.
    always_comb begin
        pick  = last;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CHANNELS; i++) begin
            cand = CH_W'((int'(last) + i) % N_CHANNELS);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        issue       = found && !tag_full && (gap == '0);
        grant       = '0;
        grant[pick] = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= CH_W'(N_CHANNELS - 1);
            gap         <= '0;
            dsp_in_data <= '0;
            dsp_in_nd   <= 1'b0;
            out_data    <= '0;
            out_nd      <= 1'b0;
            out_ch      <= '0;
            overflow    <= '0;
            tag_error   <= 1'b0;
        end else begin
            if (issue) last <= pick;
            gap <= issue ? GAP_W'(MIN_GAP) : ((gap != '0) ? gap - GAP_W'(1) : gap);
            dsp_in_nd <= issue;
            if (issue) dsp_in_data <= fifo_q[pick];
            // A push onto a full FIFO survives only when the same edge pops it.
            overflow <= overflow | (in_nd & fifo_full & ~grant);
            out_nd <= tag_pop;
            if (tag_pop) begin
                out_data <= dsp_out_data;
                out_ch   <= tag_q;
            end
            tag_error <= tag_error | (dsp_out_nd & tag_empty);
        end
    end

endmodule

// File: tb/tb_stream_share_ctrl.sv
// tb_stream_share_ctrl: three controller instances (default; MIN_GAP=2; TAG_DEPTH=4) each feeding a fixed-latency pass-through model.
module tb_stream_share_ctrl;
    localparam int W  = 32;
    localparam int NI = 3;

    typedef struct {
        int         cyc;
        logic [W-1:0] d;
        logic       ch;
    } ev_t;

    typedef struct {
        int         k;
        int         ch;
        logic [W-1:0] d;
        int         l;
        int         iss_dly;
        int         out_dly;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic [NI-1:0][2*W-1:0] in_data;
    logic [NI-1:0][1:0]     in_nd;
    logic [NI-1:0][W-1:0]   dsp_in_data;
    logic [NI-1:0]          dsp_in_nd;
    logic [NI-1:0][W-1:0]   dsp_out_data;
    logic [NI-1:0]          dsp_out_nd;
    logic [NI-1:0][W-1:0]   out_data;
    logic [NI-1:0]          out_nd;
    logic [NI-1:0]          out_ch;
    logic [NI-1:0][1:0]     overflow;
    logic [NI-1:0]          tag_error;
    logic [NI-1:0]          inj_nd;
    logic [NI-1:0][W-1:0]   inj_data;
    int                     lat [NI] = '{3, 3, 3};

    ev_t iss_q [NI][$];
    ev_t out_q [NI][$];
    int  ret_q [NI][$];
    int  outst [NI];
    int  max_outst [NI];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        logic [15:0]  dl_nd;
        logic [W-1:0] dl_d [16];

        stream_share_ctrl #(
            .WIDTH(W), .N_CHANNELS(2), .FIFO_DEPTH(4),
            .TAG_DEPTH(k == 2 ? 4 : 8), .MIN_GAP(k == 1 ? 2 : 0)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .in_data      (in_data[k]),
            .in_nd        (in_nd[k]),
            .dsp_in_data  (dsp_in_data[k]),
            .dsp_in_nd    (dsp_in_nd[k]),
            .dsp_out_data (dsp_out_data[k]),
            .dsp_out_nd   (dsp_out_nd[k]),
            .out_data     (out_data[k]),
            .out_nd       (out_nd[k]),
            .out_ch       (out_ch[k]),
            .overflow     (overflow[k]),
            .tag_error    (tag_error[k])
        );

        // Shared block model: pure delay line of lat[k] cycles, reset together with the controller.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                dl_nd <= '0;
            end else begin
                dl_nd   <= {dl_nd[14:0], dsp_in_nd[k]};
                dl_d[0] <= dsp_in_data[k];
                for (int i = 1; i < 16; i++) dl_d[i] <= dl_d[i-1];
            end
        end

        assign dsp_out_nd[k]   = dl_nd[lat[k]-1] | inj_nd[k];
        assign dsp_out_data[k] = dl_nd[lat[k]-1] ? dl_d[lat[k]-1] : inj_data[k];
    end

    always @(negedge clk) begin
        ev_t e;
        for (int k = 0; k < NI; k++) begin
            if (dsp_in_nd[k]) begin
                e.cyc = cyc; e.d = dsp_in_data[k]; e.ch = 1'b0;
                iss_q[k].push_back(e);
            end
            if (out_nd[k]) begin
                e.cyc = cyc; e.d = out_data[k]; e.ch = out_ch[k];
                out_q[k].push_back(e);
            end
            if (dsp_out_nd[k]) ret_q[k].push_back(cyc);
            outst[k] += int'(dsp_in_nd[k]) - int'(dsp_out_nd[k]);
            if (outst[k] > max_outst[k]) max_outst[k] = outst[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int k = 0; k < NI; k++) begin
            iss_q[k].delete();
            out_q[k].delete();
            ret_q[k].delete();
            outst[k]     = 0;
            max_outst[k] = 0;
        end
    endtask

    initial begin
        vec_t        tbl [5];
        logic [W-1:0] exp_q [2][$];
        int          surv [8] = '{0, 1, 2, 3, 4, 5, 7, 10};
        int          t;
        int          c;
        int          sent;
        logic [W-1:0] d;
        logic [W-1:0] last_seen [2];
        ev_t         e;

        // Single-sample latencies: issue 2 cycles after in_nd, result L+1 cycles after issue.
        // Instance 0 ends on a ch1 grant, so channel 0 has priority for the contention burst.
        tbl[0] = '{0, 0, 32'h0000_0123, 3, 2, 6};
        tbl[1] = '{0, 1, 32'hDEAD_BEEF, 1, 2, 4};
        tbl[2] = '{1, 0, 32'hFFFF_FFFF, 5, 2, 8};
        tbl[3] = '{2, 1, 32'h0000_0000, 2, 2, 5};
        tbl[4] = '{1, 1, 32'h5A5A_5A5A, 4, 2, 7};

        rst = 1'b1; in_nd = '0; in_data = '0; inj_nd = '0; inj_data = '0;
        tick(2);
        for (int k = 0; k < NI; k++) begin
            chk("reset_flags", {dsp_in_nd[k], out_nd[k], out_ch[k], overflow[k], tag_error[k]}, 0);
            chk("reset_data", {dsp_in_data[k], out_data[k]}, 0);
        end
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            lat[tbl[i].k] = tbl[i].l;
            clear_mon();
            t = cyc;
            in_nd[tbl[i].k][tbl[i].ch] = 1'b1;
            in_data[tbl[i].k][tbl[i].ch*W +: W] = tbl[i].d;
            tick();
            in_nd[tbl[i].k] = '0;
            tick(14);
            chk("tbl_issue_count", iss_q[tbl[i].k].size(), 1);
            if (iss_q[tbl[i].k].size() > 0) begin
                chk("tbl_issue_delay", iss_q[tbl[i].k][0].cyc - t, tbl[i].iss_dly);
                chk("tbl_issue_data", iss_q[tbl[i].k][0].d, tbl[i].d);
            end
            chk("tbl_out_count", out_q[tbl[i].k].size(), 1);
            if (out_q[tbl[i].k].size() > 0) begin
                chk("tbl_out_delay", out_q[tbl[i].k][0].cyc - t, tbl[i].out_dly);
                chk("tbl_out_data", out_q[tbl[i].k][0].d, tbl[i].d);
                chk("tbl_out_ch", out_q[tbl[i].k][0].ch, tbl[i].ch);
            end
            chk("tbl_flags", {overflow[tbl[i].k], tag_error[tbl[i].k]}, 0);
        end

        // Contention: both channels 4 samples on the same cycles, alternating back-to-back.
        lat[0] = 3;
        clear_mon();
        t = cyc;
        for (int i = 0; i < 4; i++) begin
            in_nd[0] = 2'b11;
            in_data[0] = {32'(32'hB0 + i), 32'(32'hA0 + i)};
            tick();
        end
        in_nd[0] = '0;
        tick(16);
        chk("cont_issue_count", iss_q[0].size(), 8);
        for (int i = 0; i < 8 && i < iss_q[0].size(); i++) begin
            chk("cont_issue_data", iss_q[0][i].d, ((i % 2) ? 32'hB0 : 32'hA0) + 32'(i / 2));
            chk("cont_issue_cycle", iss_q[0][i].cyc - t, 2 + i);
        end
        chk("cont_out_count", out_q[0].size(), 8);
        for (int i = 0; i < 8 && i < out_q[0].size(); i++) begin
            chk("cont_out_data", out_q[0][i].d, ((i % 2) ? 32'hB0 : 32'hA0) + 32'(i / 2));
            chk("cont_out_ch", out_q[0][i].ch, i % 2);
        end
        chk("cont_overflow", overflow[0], 0);

        // Random traffic, at most one sample per cycle, checked per channel against in-order queues.
        for (int run = 0; run < 2; run++) begin
            lat[0] = run ? 6 : 1;
            clear_mon();
            sent = 0;
            for (int n = 0; n < 150; n++) begin
                in_nd[0] = '0;
                if ($urandom_range(9) < 6) begin
                    c = int'($urandom_range(1));
                    d = $urandom();
                    in_nd[0][c] = 1'b1;
                    in_data[0][c*W +: W] = d;
                    exp_q[c].push_back(d);
                    sent++;
                end
                tick();
            end
            in_nd[0] = '0;
            tick(20);
            chk("rnd_out_count", out_q[0].size(), sent);
            foreach (out_q[0][i]) begin
                e = out_q[0][i];
                if (exp_q[e.ch].size() > 0) chk("rnd_out_data", e.d, exp_q[e.ch].pop_front());
                else chk("rnd_unexpected_out", e.d, 0);
            end
            chk("rnd_leftover", exp_q[0].size() + exp_q[1].size(), 0);
            exp_q[0].delete();
            exp_q[1].delete();
            chk("rnd_flags", {overflow[0], tag_error[0]}, 0);
        end

        // Spurious result with nothing in flight.
        lat[0] = 3;
        clear_mon();
        inj_nd[0] = 1'b1; inj_data[0] = 32'h77;
        tick();
        inj_nd[0] = 1'b0;
        tick(3);
        chk("spur_tag_error", tag_error[0], 1);
        chk("spur_no_out", out_q[0].size(), 0);
        in_nd[0] = 2'b10; in_data[0][W +: W] = 32'h99;
        tick();
        in_nd[0] = '0;
        tick(12);
        chk("spur_after_count", out_q[0].size(), 1);
        if (out_q[0].size() > 0) begin
            chk("spur_after_data", out_q[0][0].d, 32'h99);
            chk("spur_after_ch", out_q[0][0].ch, 1);
        end
        chk("spur_sticky", tag_error[0], 1);

        // Reset in the middle of a contention burst.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            in_nd[0] = 2'b11;
            in_data[0] = {32'(32'hB0 + i), 32'(32'hA0 + i)};
            tick();
        end
        in_nd[0] = '0;
        rst = 1'b1;
        #1;
        chk("rstmid_flags", {dsp_in_nd[0], out_nd[0], out_ch[0], overflow[0], tag_error[0]}, 0);
        chk("rstmid_data", {dsp_in_data[0], out_data[0]}, 0);
        tick(2);
        rst = 1'b0;
        tick();
        clear_mon();
        in_nd[0] = 2'b10; in_data[0][W +: W] = 32'h55;
        tick();
        in_nd[0] = '0;
        tick(12);
        chk("rstmid_issue_count", iss_q[0].size(), 1);
        chk("rstmid_out_count", out_q[0].size(), 1);
        if (out_q[0].size() > 0) begin
            chk("rstmid_out_data", out_q[0][0].d, 32'h55);
            chk("rstmid_out_ch", out_q[0][0].ch, 1);
        end
        chk("rstmid_tag_error", tag_error[0], 0);

        // MIN_GAP=2: ch0 every cycle for 12 cycles; FIFO of 4 drained every 3 cycles drops s6,s8,s9,s11.
        lat[1] = 3;
        clear_mon();
        t = cyc;
        for (int i = 0; i < 12; i++) begin
            in_nd[1] = 2'b01;
            in_data[1][W-1:0] = 32'(32'h100 + i);
            tick();
        end
        in_nd[1] = '0;
        tick(40);
        chk("gap_issue_count", iss_q[1].size(), 8);
        if (iss_q[1].size() > 0) chk("gap_first_issue", iss_q[1][0].cyc - t, 2);
        for (int i = 0; i < 8 && i < iss_q[1].size(); i++) begin
            chk("gap_issue_data", iss_q[1][i].d, 32'(32'h100 + surv[i]));
            if (i > 0) chk("gap_spacing", iss_q[1][i].cyc - iss_q[1][i-1].cyc, 3);
        end
        chk("gap_out_count", out_q[1].size(), 8);
        for (int i = 0; i < 8 && i < out_q[1].size(); i++) chk("gap_out_data", out_q[1][i].d, 32'(32'h100 + surv[i]));
        chk("gap_overflow", overflow[1], 2'b01);

        // TAG_DEPTH=4, L=10, both channels saturated.
        lat[2] = 10;
        clear_mon();
        for (int i = 0; i < 40; i++) begin
            in_nd[2] = 2'b11;
            in_data[2] = {32'(32'h2000 + i), 32'(32'h1000 + i)};
            tick();
        end
        in_nd[2] = '0;
        tick(60);
        chk("inflight_max", max_outst[2], 4);
        chk("inflight_resume_seen", (iss_q[2].size() > 4) && (ret_q[2].size() > 0), 1);
        if ((iss_q[2].size() > 4) && (ret_q[2].size() > 0)) chk("inflight_resume", iss_q[2][4].cyc - ret_q[2][0], 2);
        chk("inflight_out_count", out_q[2].size(), iss_q[2].size());
        last_seen[0] = '0;
        last_seen[1] = '0;
        foreach (out_q[2][i]) begin
            e = out_q[2][i];
            chk("inflight_ch", e.ch, e.d[13]);
            chk("inflight_order", e.d > last_seen[e.ch], 1);
            last_seen[e.ch] = e.d;
        end
        chk("inflight_overflow", overflow[2], 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/stream_share_ctrl.md
Name: stream_share_ctrl

Overview:
- Time-shares one streaming DSP block (WIDTH-bit data plus "new data" strobe, in-order, latency unknown but at least 1 cycle) between N_CHANNELS independent sample streams.
- Buffers each channel, schedules samples into the shared block round-robin with optional minimum spacing, and tags each issued sample with its channel.
- Routes each result back out with its channel index.
- Sits between the per-channel front ends and the shared qa-style processing block.

Parameters:
WIDTH, 32, sample width in bits
N_CHANNELS, 2, number of requesting streams (>=2)
FIFO_DEPTH, 4, per-channel input FIFO depth (power of 2)
TAG_DEPTH, 8, max samples in flight in the shared block (power of 2)
MIN_GAP, 0, minimum idle cycles between consecutive dsp_in_nd pulses

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_data  in  N_CHANNELS*WIDTH  per-channel samples, channel c at bits [c*WIDTH +: WIDTH]
in_nd  in  N_CHANNELS  per-channel new-data strobes
dsp_in_data  out  WIDTH  sample to shared block
dsp_in_nd  out  1  strobe to shared block
dsp_out_data  in  WIDTH  result from shared block
dsp_out_nd  in  1  result strobe from shared block
out_data  out  WIDTH  routed result
out_nd  out  1  result strobe
out_ch  out  CH_W  channel of result, CH_W = max(1, clog2(N_CHANNELS))
overflow  out  N_CHANNELS  sticky per-channel drop flag
tag_error  out  1  sticky: result arrived with no sample in flight

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset:
  - All outputs 0; FIFOs and tag FIFO empty; gap counter 0.
  - Round-robin pointer set so channel 0 has highest priority.
  - Reset mid-operation discards buffered and in-flight samples. The shared block must be reset together with this block.
- Input capture:
  - in_nd[c] writes in_data[c] into FIFO c.
  - If FIFO c is full and not popped that cycle, the sample is dropped and overflow[c] is set. Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- Issue eligibility: any FIFO non-empty AND tag FIFO not full AND gap counter == 0.
- Grant:
  - Round-robin, searching from (last granted + 1) mod N_CHANNELS.
  - Grant pops that FIFO. dsp_in_data and dsp_in_nd are registered and asserted the next cycle. The channel index is pushed to the tag FIFO on the same edge.
- Latency, idle system: in_nd at cycle t -> dsp_in_nd at t+2.
- Gap counter:
  - Loaded with MIN_GAP on each issue; decrements to 0.
  - Consecutive dsp_in_nd pulses are therefore at least MIN_GAP+1 cycles apart.
  - MIN_GAP=0 allows back-to-back issue.
- Return path:
  - dsp_out_nd pops the tag FIFO.
  - out_data = dsp_out_data and out_ch = popped tag, with out_nd = 1, all registered: one cycle after dsp_out_nd.
  - out_nd is a single-cycle pulse per result.
  - dsp_out_nd with the tag FIFO empty sets tag_error; out_nd stays 0 and the result is dropped.
  - Push and pop of the tag FIFO in the same cycle are both honoured.
- Sticky flags: overflow and tag_error clear only on rst.
- Ordering: per-channel sample order is preserved end to end.

Decomposition:
- Shared package: clog2 function, CH_W derivation, channel-index slicing helper for the flattened in_data bus.
- Sub-module: sync_fifo (parameterised WIDTH/DEPTH, push, pop, full, empty, async active-high reset).
  - Instantiated N_CHANNELS times for sample buffering.
  - Instantiated once with WIDTH=CH_W, DEPTH=TAG_DEPTH for tags.
- Arbiter, gap counter and output register live in the top module.

Test Plan:
- Bench model: pass-through shared block of fixed latency L.
- Single sample: ch0 0x00000123 at cycle t, L=3, MIN_GAP=0 -> dsp_in_nd at t+2; out_nd at t+6 with out_data=0x00000123, out_ch=0; no flags.
- Contention: ch0 sends 0xA0..0xA3 and ch1 sends 0xB0..0xB3 on the same 4 cycles -> dsp_in_data order A0,B0,A1,B1,A2,B2,A3,B3 back-to-back; each output carries the correct out_ch; overflow=0.
- Spacing/overflow: MIN_GAP=2, FIFO_DEPTH=4, ch0 in_nd every cycle for 12 cycles -> dsp_in_nd exactly every 3 cycles; overflow[0]=1; dropped samples never appear at out_data; surviving samples in order.
- In-flight limit: TAG_DEPTH=4, L=10, both channels saturated -> never more than 4 dsp_in_nd pulses outstanding; issue resumes the cycle after the first dsp_out_nd.
- Spurious result: dsp_out_nd with nothing issued -> tag_error=1, out_nd remains 0; later normal traffic still routes correctly.
- Reset mid-burst: assert rst during the contention scenario -> all outputs 0 immediately; flags cleared; after release, next ch1-only sample 0x55 emerges with out_ch=1 and no tag_error (shared block also reset).
